pwm_bank: RTL and testbench
===========================

# pwm_bank

Parametrised multi-channel PWM generator that consumes configuration words popped from the SPI receive FIFO and drives `NUM_CH` PWM outputs. It is the successor of the fixed four-output PWM stage. It adds a channel-address field, a broadcast mode, and per-channel shadow registers so that new duty/period values take effect only at a period boundary (glitch-free). It adds a ready/valid command handshake and per-channel update/period status pulses.

## Interface
- `NUM_CH`, 4: number of PWM channels, ≥2.
- `CNT_W`, 8: width of duty, period and counter.
- `CH_W`, $clog2(NUM_CH): channel-select width (derived, not overridden).
- `CMD_W`, 1+CH_W+2*CNT_W: command word width (derived).
- `clk  input  1`: system clock.
- `rst  input  1`: reset; asynchronous and active-low.
- `cmd_data  input  CMD_W`: command word `{bcast, ch_sel, duty, period}`, MSB first; `period` is in the low `CNT_W` bits.
- `cmd_valid  input  1`: command present.
- `cmd_ready  output  1`: command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `pwm_out  output  NUM_CH`: registered PWM outputs.
- `upd_done  output  NUM_CH`: one-cycle pulse when a channel's shadow is loaded into its active registers.
- `period_start  output  NUM_CH`: one-cycle pulse in the cycle the channel's counter is 0 while the channel is enabled.

## Operation
- **Per-channel state:**
  - active `duty_a`, `per_a`;
  - shadow `duty_s`, `per_s`;
  - `pending` flag;
  - counter `cnt` (`CNT_W` bits).
- **Reset (rst low, asynchronous):**
  - all registers are 0;
  - `pwm_out` = 0, `upd_done` = 0, `period_start` = 0;
  - `cmd_ready` = 1 once `rst` is high.
- **Accept:**
  - `bcast` = 0: targets channel `ch_sel`. If `ch_sel` ≥ `NUM_CH`, the word is accepted and dropped, with no state change.
  - `bcast` = 1: targets all channels; `ch_sel` is ignored.
  - On accept, each target gets `duty_s`/`per_s` written and `pending` set.
- **cmd_ready:** low iff any target of the presented `cmd_data` has `pending` = 1. This is combinational on `cmd_data` and `pending`. When `cmd_valid` = 0, ready reflects the decoded target of the current `cmd_data`.
- **Channel enabled:** `per_a` ≠ 0. The counter runs 0 .. `per_a`−1, then wraps to 0.
- **Boundary:** the cycle in which `per_a` = 0, or `cnt` = `per_a`−1.
  - If `pending` is set at a boundary, the next edge loads active from shadow, clears `pending`, sets `cnt` to 0 and pulses `upd_done`.
  - Otherwise the counter wraps normally.
- **Output:** `pwm_out` is registered as `(per_a != 0) && (cnt < duty_a)`.
  - `duty` = 0 gives constant low.
  - `duty` ≥ `per_a` gives constant high.
  - `per_a` = 0 gives low (channel disabled).
- **Simultaneous accept and apply on the same channel:** cannot occur, because ready is low while `pending` is set.
  - An accept in the apply cycle of a different channel is independent.
  - After apply, ready for that channel rises on the next cycle.
- **Arithmetic:** all comparisons are unsigned `CNT_W`-bit; `per_a`−1 never underflows because it is only evaluated when `per_a` ≠ 0.

## Timing
- **Accept at edge T:** `pending` = 1 and `cmd_ready` for that target = 0 from T.
- **Disabled channel:** apply at edge T+1, with `upd_done` high in cycle T+1..T+2.
  - `cnt` = 0 after T+1.
  - First `pwm_out` reflecting new values after T+2 (one register stage).
- **Enabled channel:** apply at the edge following the cycle where `cnt` = `per_a`−1. Worst-case latency is `per_a` cycles plus 1.
- **period_start** is asserted when `cnt` = 0 and `per_a` ≠ 0, aligned one cycle before the corresponding `pwm_out` edge.
- **Reset mid-period:** outputs go low immediately, and shadow/pending contents are discarded.

## Structure
- Package `pwm_pkg` holds:
  - command field offset/width functions of `NUM_CH`, `CNT_W`: `BCAST_BIT`, `CH_LSB`, `DUTY_LSB`, `PER_LSB`;
  - reset constants.
- Sub-module `pwm_channel` contains per-channel shadow/active registers, counter, pending flag, output register and status pulses.
  - Inputs: `wr_en`, `duty`, `per`.
  - Outputs: `pending`, `pwm`, `upd`, `pstart`.
- `pwm_bank` keeps only command decode, `cmd_ready` logic and a generate loop of `NUM_CH` instances.

## Test plan
Bench uses `NUM_CH`=4, `CNT_W`=8, so `CMD_W`=19.
- **Reset:** hold `rst` low with `cmd_valid` = 1 → all `pwm_out` = 0, no `upd_done`; after release, `cmd_ready` = 1.
- **Single channel from disabled:**
  - Stimulus: `{0, 2'd1, 8'd10, 8'd30}`.
  - Response: `upd_done[1]` one cycle after accept; `pwm_out[1]` high 10 cycles, low 20, period 30; other channels stay low.
- **Glitch-free update:**
  - Stimulus: while ch1 runs 10/30, send `{0, 1, 20, 10}` mid-period.
  - Response:
    - `cmd_ready` for ch1 is low until the apply;
    - the apply is coincident with the period wrap;
    - a second ch1 word is stalled;
    - a ch2 word is accepted immediately;
    - afterwards ch1 is constant high (duty 20 ≥ period 10).
- **Broadcast:**
  - Stimulus: `{1, x, 30, 20}` with all channels disabled.
  - Response: all four `upd_done` pulse in the same cycle; all outputs are high 20 of 20 (constant); `period_start` is aligned on all channels.
- **Edges:**
  - `duty` = 0 → constant low.
  - `period` = 0 written → channel disables at the next boundary, output low.
  - `period` = 255, `duty` = 1 → one high cycle per 255.
  - `ch_sel` = 3 works; with `NUM_CH` = 3, `ch_sel` = 3 is accepted and has no effect.
- **Reset mid-operation:** assert `rst` low while ch0 is pending → outputs drop asynchronously, `pending` is cleared, no `upd_done` after release.

Source files
------------

// File: rtl/pwm_pkg.sv
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Command-word field layout and reset constants for pwm_bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

  localparam logic PWM_RST     = 1'b0;
  localparam logic PENDING_RST = 1'b0;
  localparam logic UPD_RST     = 1'b0;

  function automatic int ch_w(input int num_ch);
    return $clog2(num_ch);
  endfunction

  function automatic int cmd_w(input int num_ch, input int cnt_w);
    return 1 + $clog2(num_ch) + 2 * cnt_w;
  endfunction

  // Word layout, MSB first: {bcast, ch_sel, duty, period}
  function automatic int per_lsb();
    return 0;
  endfunction

  function automatic int duty_lsb(input int cnt_w);
    return cnt_w;
  endfunction

  function automatic int ch_lsb(input int cnt_w);
    return 2 * cnt_w;
  endfunction

  function automatic int bcast_bit(input int num_ch, input int cnt_w);
    return 2 * cnt_w + $clog2(num_ch);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_bank_if.sv
// ============================================================================
// Module   : pwm_bank_if
// Purpose  : Ready/valid command channel feeding pwm_bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_bank_if #(
  parameter int CMD_W = 19
) ();

  logic [CMD_W-1:0] cmd_data;
  logic             cmd_valid;
  logic             cmd_ready;

  modport master (
    output cmd_data,
    output cmd_valid,
    input  cmd_ready
  );

  modport slave (
    input  cmd_data,
    input  cmd_valid,
    output cmd_ready
  );

endinterface

`default_nettype wire

// File: rtl/pwm_channel.sv
// ============================================================================
// Module   : pwm_channel
// Purpose  : One PWM channel with shadow/active registers and boundary update.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] per,
  output logic             pending,
  output logic             pwm,
  output logic             upd,
  output logic             pstart
);

  logic [CNT_W-1:0] duty_a_q, duty_a_d;
  logic [CNT_W-1:0] per_a_q,  per_a_d;
  logic [CNT_W-1:0] duty_s_q, duty_s_d;
  logic [CNT_W-1:0] per_s_q,  per_s_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             pending_q, pending_d;
  logic             pwm_q,     pwm_d;
  logic             upd_q,     upd_d;

  logic             enabled;
  logic             boundary;
  logic             apply;
  logic [CNT_W-1:0] last_cnt;

  always_comb begin
    enabled  = (per_a_q != '0);
    // Only meaningful while enabled, so the decrement never wraps in use
    last_cnt = per_a_q - CNT_W'(1);
    boundary = !enabled || (cnt_q == last_cnt);
    apply    = boundary && pending_q;
  end

  always_comb begin
    duty_a_d  = duty_a_q;
    per_a_d   = per_a_q;
    duty_s_d  = duty_s_q;
    per_s_d   = per_s_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;

    if (apply) begin
      duty_a_d  = duty_s_q;
      per_a_d   = per_s_q;
      pending_d = 1'b0;
    end

    if (wr_en) begin
      duty_s_d  = duty;
      per_s_d   = per;
      pending_d = 1'b1;
    end

    if (boundary) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    pwm_d = enabled && (cnt_q < duty_a_q);
    upd_d = apply;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_a_q  <= '0;
      per_a_q   <= '0;
      duty_s_q  <= '0;
      per_s_q   <= '0;
      cnt_q     <= '0;
      pending_q <= PENDING_RST;
      pwm_q     <= PWM_RST;
      upd_q     <= UPD_RST;
    end else begin
      duty_a_q  <= duty_a_d;
      per_a_q   <= per_a_d;
      duty_s_q  <= duty_s_d;
      per_s_q   <= per_s_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      pwm_q     <= pwm_d;
      upd_q     <= upd_d;
    end
  end

  assign pending = pending_q;
  assign pwm     = pwm_q;
  assign upd     = upd_q;
  // Leads the matching pwm edge by one cycle because pwm is registered
  assign pstart  = enabled && (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/pwm_bank.sv
// ============================================================================
// Module   : pwm_bank
// Purpose  : Multi-channel PWM bank with addressed/broadcast glitch-free updates.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_bank
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  pwm_bank_if.slave         cmd,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] upd_done,
  output logic [NUM_CH-1:0] period_start
);

  localparam int CH_W      = ch_w(NUM_CH);
  localparam int BCAST_BIT = bcast_bit(NUM_CH, CNT_W);
  localparam int CH_LSB    = ch_lsb(CNT_W);
  localparam int DUTY_LSB  = duty_lsb(CNT_W);
  localparam int PER_LSB   = per_lsb();

  logic              bcast;
  logic [CH_W-1:0]   ch_sel;
  logic [CNT_W-1:0]  duty;
  logic [CNT_W-1:0]  per;
  logic [NUM_CH-1:0] target;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] wr_en;
  logic              ready;

  assign bcast  = cmd.cmd_data[BCAST_BIT];
  assign ch_sel = cmd.cmd_data[CH_LSB +: CH_W];
  assign duty   = cmd.cmd_data[DUTY_LSB +: CNT_W];
  assign per    = cmd.cmd_data[PER_LSB +: CNT_W];

  // Out-of-range addresses decode to no target: accepted and dropped
  always_comb begin
    target = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bcast || (int'(ch_sel) == i)) begin
        target[i] = 1'b1;
      end
    end
  end

  always_comb begin
    ready = ~|(target & pending);
    wr_en = target & {NUM_CH{cmd.cmd_valid && ready}};
  end

  assign cmd.cmd_ready = ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[g]),
      .duty    (duty),
      .per     (per),
      .pending (pending[g]),
      .pwm     (pwm_out[g]),
      .upd     (upd_done[g]),
      .pstart  (period_start[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_bank.sv
// ============================================================================
// Module   : tb_pwm_bank
// Purpose  : Directed self-checking bench for pwm_bank (4-channel and 3-channel).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pwm_out, upd_done, period_start;
  logic [2:0] pwm_out3, upd_done3, period_start3;

  int n_vec = 0;
  int n_err = 0;

  pwm_bank_if #(.CMD_W(19)) cmd  ();
  pwm_bank_if #(.CMD_W(19)) cmd3 ();

  pwm_bank #(.NUM_CH(4), .CNT_W(8)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cmd),
    .pwm_out      (pwm_out),
    .upd_done     (upd_done),
    .period_start (period_start)
  );

  pwm_bank #(.NUM_CH(3), .CNT_W(8)) u_dut3 (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cmd3),
    .pwm_out      (pwm_out3),
    .upd_done     (upd_done3),
    .period_start (period_start3)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] mk(input logic b, input logic [1:0] ch,
                                     input logic [7:0] d, input logic [7:0] p);
    return {b, ch, d, p};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [18:0] d);
    int k;
    cmd.cmd_data  = d;
    cmd.cmd_valid = 1'b1;
    #1;
    k = 0;
    while (!cmd.cmd_ready && k < 300) begin
      @(posedge clk);
      #2;
      k++;
    end
    check("send_ready", 32'(cmd.cmd_ready), 32'd1);
    tick();
    cmd.cmd_valid = 1'b0;
  endtask

  task automatic wait_upd(input int idx, input int bound, output int n);
    n = 0;
    while (upd_done[idx] !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n, hi, hi2, acc, acc2;

    // Reset held with a valid command present
    rst            = 1'b0;
    cmd.cmd_valid  = 1'b1;
    cmd.cmd_data   = mk(1'b1, 2'd0, 8'd5, 8'd5);
    cmd3.cmd_valid = 1'b1;
    cmd3.cmd_data  = mk(1'b1, 2'd0, 8'd5, 8'd5);
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm",    32'(pwm_out), 32'h0);
    check("rst_upd",    32'(upd_done), 32'h0);
    check("rst_pstart", 32'(period_start), 32'h0);
    check("rst_pwm3",   32'(pwm_out3), 32'h0);
    cmd.cmd_valid  = 1'b0;
    cmd3.cmd_valid = 1'b0;
    #1 rst = 1'b1;
    #1 check("rst_ready", 32'(cmd.cmd_ready), 32'd1);
    tick();

    // Single channel from disabled: ch1 duty 10 period 30
    cmd.cmd_data  = mk(1'b0, 2'd1, 8'd10, 8'd30);
    cmd.cmd_valid = 1'b1;
    #1 check("t1_ready", 32'(cmd.cmd_ready), 32'd1);
    tick();
    cmd.cmd_valid = 1'b0;
    #1;
    check("t1_busy",    32'(cmd.cmd_ready), 32'd0);
    check("t1_no_upd",  32'(upd_done), 32'h0);
    tick();
    check("t1_upd",     32'(upd_done), 32'h2);
    check("t1_rdy_back", 32'(cmd.cmd_ready), 32'd1);
    check("t1_pstart",  32'(period_start), 32'h2);
    check("t1_pwm_lat", 32'(pwm_out), 32'h0);
    tick();
    hi = 0; acc = 0;
    for (int i = 0; i < 30; i++) begin
      hi  += int'(pwm_out[1]);
      acc |= int'(pwm_out & 4'b1101);
      tick();
    end
    check("t1_high_cnt", 32'(hi), 32'd10);
    check("t1_others",   32'(acc), 32'd0);
    check("t1_period",   32'(pwm_out), 32'h2);

    // Glitch-free update on ch1 mid-period (counter currently 1)
    cmd.cmd_data  = mk(1'b0, 2'd1, 8'd20, 8'd10);
    cmd.cmd_valid = 1'b1;
    #1 check("t2_ready", 32'(cmd.cmd_ready), 32'd1);
    tick();
    cmd.cmd_data = mk(1'b0, 2'd1, 8'd5, 8'd7);
    #1 check("t2_stall", 32'(cmd.cmd_ready), 32'd0);
    tick();
    #1 check("t2_stall2", 32'(cmd.cmd_ready), 32'd0);
    cmd.cmd_data = mk(1'b0, 2'd2, 8'd3, 8'd4);
    #1 check("t2_ch2_ready", 32'(cmd.cmd_ready), 32'd1);
    tick();
    cmd.cmd_valid = 1'b0;
    cmd.cmd_data  = mk(1'b0, 2'd1, 8'd5, 8'd7);
    tick();
    check("t2_ch2_upd", 32'(upd_done), 32'h4);
    n = 0; acc = 0;
    while (upd_done[1] !== 1'b1 && n < 40) begin
      acc |= int'(cmd.cmd_ready);
      tick();
      n++;
    end
    check("t2_apply_lat",  32'(n), 32'd25);
    check("t2_ready_low",  32'(acc), 32'd0);
    check("t2_wrap",       32'(period_start[1]), 32'd1);
    check("t2_ready_back", 32'(cmd.cmd_ready), 32'd1);
    tick();
    hi = 0; hi2 = 0;
    for (int i = 0; i < 8; i++) begin
      hi  += int'(pwm_out[1]);
      hi2 += int'(pwm_out[2]);
      tick();
    end
    check("t2_ch1_const_hi", 32'(hi), 32'd8);
    check("t2_ch2_3of4",     32'(hi2), 32'd6);

    // Reset while ch0 is pending
    check("t5_pre", 32'(pwm_out[1]), 32'd1);
    cmd.cmd_data  = mk(1'b0, 2'd0, 8'd5, 8'd6);
    cmd.cmd_valid = 1'b1;
    tick();
    cmd.cmd_valid = 1'b0;
    #1 check("t5_pending", 32'(cmd.cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("t5_async",    32'(pwm_out), 32'h0);
    check("t5_pend_clr", 32'(cmd.cmd_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    acc = 0; acc2 = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      acc  |= int'(upd_done);
      acc2 |= int'(pwm_out);
    end
    check("t5_no_upd", 32'(acc), 32'd0);
    check("t5_low",    32'(acc2), 32'd0);

    // Three-channel bank: ch_sel 3 dropped, ch_sel 2 applied
    cmd3.cmd_data  = mk(1'b0, 2'd3, 8'd10, 8'd30);
    cmd3.cmd_valid = 1'b1;
    #1 check("t6_ready", 32'(cmd3.cmd_ready), 32'd1);
    tick();
    cmd3.cmd_valid = 1'b0;
    tick();
    check("t6_drop",     32'(upd_done3), 32'h0);
    check("t6_drop_rdy", 32'(cmd3.cmd_ready), 32'd1);
    cmd3.cmd_data  = mk(1'b0, 2'd2, 8'd10, 8'd30);
    cmd3.cmd_valid = 1'b1;
    tick();
    cmd3.cmd_valid = 1'b0;
    tick();
    check("t6_ch2", 32'(upd_done3), 32'h4);

    // Broadcast 30/20 on all disabled channels; ch_sel ignored
    cmd.cmd_data  = mk(1'b1, 2'd2, 8'd30, 8'd20);
    cmd.cmd_valid = 1'b1;
    #1 check("t3_ready", 32'(cmd.cmd_ready), 32'd1);
    tick();
    cmd.cmd_valid = 1'b0;
    check("t3_no_upd", 32'(upd_done), 32'h0);
    tick();
    check("t3_upd",    32'(upd_done), 32'hf);
    check("t3_pstart", 32'(period_start), 32'hf);
    tick();
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (pwm_out == 4'hf) hi++;
      if (i == 19) check("t3_pstart_wrap", 32'(period_start), 32'hf);
      tick();
    end
    check("t3_all_high", 32'(hi), 32'd20);

    // duty 0 on ch0: applied at the period boundary, then constant low
    send(mk(1'b0, 2'd0, 8'd0, 8'd5));
    wait_upd(0, 40, n);
    check("t4_d0_lat", 32'(n), 32'd18);
    tick();
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      acc |= int'(pwm_out[0]);
      tick();
    end
    check("t4_d0_low", 32'(acc), 32'd0);

    // period 0 on ch1: disables at the next boundary
    send(mk(1'b0, 2'd1, 8'd7, 8'd0));
    wait_upd(1, 40, n);
    check("t4_p0_upd", 32'(upd_done[1]), 32'd1);
    tick();
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      acc |= int'(pwm_out[1] | period_start[1]);
      tick();
    end
    check("t4_p0_off", 32'(acc), 32'd0);

    // period 255 duty 1 on ch3: one high cycle per period
    send(mk(1'b0, 2'd3, 8'd1, 8'd255));
    wait_upd(3, 40, n);
    check("t4_ch3_upd",    32'(upd_done[3]), 32'd1);
    check("t4_ch3_pstart", 32'(period_start[3]), 32'd1);
    tick();
    hi = 0;
    for (int i = 0; i < 255; i++) begin
      hi += int'(pwm_out[3]);
      tick();
    end
    check("t4_ch3_one_hi", 32'(hi), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
